hsv_to_rgb: RTL and testbench

Pipelined converter from 12-bit HSV pixels (4-bit hue, saturation, value) back to 12-bit RGB (4 bits per channel). It is the inverse of the team's RGB→HSV stage. It sits after the HSV-domain processing (thresholding and hue shifts) and before the VGA pixel mux. It uses integer sextant arithmetic only and no divider IP, so latency is fixed, and the pipeline supports downstream stall.

---
 rtl/hsv_to_rgb_if.sv | 28 ++
 rtl/hsv_to_rgb.sv | 211 +++++++++++++++++++++
 tb/tb_hsv_to_rgb.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/hsv_to_rgb_if.sv
// Pixel stream bundle for hsv_to_rgb: HSV input handshake, RGB output handshake.
// Signal names match the converter's pixel-port names; slave is the converter side.
interface hsv_to_rgb_if;
  logic        valid_in;
  logic [11:0] hsv;
  logic        ready_in;
  logic        ready_out;
  logic        valid_out;
  logic [11:0] rgb;

  modport slave (
    input  valid_in,
    input  hsv,
    input  ready_in,
    output ready_out,
    output valid_out,
    output rgb
  );

  modport master (
    output valid_in,
    output hsv,
    output ready_in,
    input  ready_out,
    input  valid_out,
    input  rgb
  );
endinterface

// File: rtl/hsv_to_rgb.sv
// Pipelined 12-bit HSV -> 12-bit RGB converter using sextant arithmetic, fixed latency, stallable.
// Optional macro HSV_ROUND_EN: round (instead of truncate) when narrowing 8-bit channels to 4 bits.
module hsv_to_rgb (
  input logic         clk_in,
  input logic         rst_n_in,
  hsv_to_rgb_if.slave bus
);

  localparam int unsigned CW = 8;
  localparam int unsigned NW = 4;
  localparam int unsigned PW = 16;

  localparam logic [2:0] RGN_0 = 3'd0;
  localparam logic [2:0] RGN_1 = 3'd1;
  localparam logic [2:0] RGN_2 = 3'd2;
  localparam logic [2:0] RGN_3 = 3'd3;
  localparam logic [2:0] RGN_4 = 3'd4;
  localparam logic [2:0] RGN_5 = 3'd5;

  logic w_en;
  assign w_en          = bus.ready_in;
  assign bus.ready_out = bus.ready_in;

  // ---------------- S1: scale to 8 bits, find sextant ----------------
  logic [NW-1:0] w_h, w_s, w_v;
  logic [CW-1:0] w_h8, w_s8, w_v8, w_base, w_rem;
  logic [2:0]    w_region;

  assign w_h = bus.hsv[11:8];
  assign w_s = bus.hsv[7:4];
  assign w_v = bus.hsv[3:0];
  // x*17 for a nibble is the nibble replicated
  assign w_h8 = {w_h, w_h};
  assign w_s8 = {w_s, w_s};
  assign w_v8 = {w_v, w_v};

  always_comb begin
    w_region = RGN_0;
    w_base   = 8'd0;
    if (w_h8 >= 8'd215) begin
      w_region = RGN_5;
      w_base   = 8'd215;
    end else if (w_h8 >= 8'd172) begin
      w_region = RGN_4;
      w_base   = 8'd172;
    end else if (w_h8 >= 8'd129) begin
      w_region = RGN_3;
      w_base   = 8'd129;
    end else if (w_h8 >= 8'd86) begin
      w_region = RGN_2;
      w_base   = 8'd86;
    end else if (w_h8 >= 8'd43) begin
      w_region = RGN_1;
      w_base   = 8'd43;
    end
  end

  assign w_rem = CW'(CW'(w_h8 - w_base) * 8'd6);

  logic          r_s1_valid, r_s1_gray;
  logic [CW-1:0] r_s1_s8, r_s1_v8, r_s1_rem;
  logic [2:0]    r_s1_region;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_s1_valid  <= 1'b0;
      r_s1_gray   <= 1'b0;
      r_s1_s8     <= '0;
      r_s1_v8     <= '0;
      r_s1_rem    <= '0;
      r_s1_region <= '0;
    end else if (w_en) begin
      r_s1_valid  <= bus.valid_in;
      r_s1_gray   <= (w_s == 4'd0);
      r_s1_s8     <= w_s8;
      r_s1_v8     <= w_v8;
      r_s1_rem    <= w_rem;
      r_s1_region <= w_region;
    end
  end

  // ---------------- S2: saturation terms ----------------
  logic [CW-1:0] w_rem_inv;
  logic [PW-1:0] w_prod_q, w_prod_t;

  assign w_rem_inv = 8'd255 - r_s1_rem;
  assign w_prod_q  = PW'(r_s1_s8) * PW'(r_s1_rem);
  assign w_prod_t  = PW'(r_s1_s8) * PW'(w_rem_inv);

  logic          r_s2_valid, r_s2_gray;
  logic [CW-1:0] r_s2_ps, r_s2_qs, r_s2_ts, r_s2_v8;
  logic [2:0]    r_s2_region;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_s2_valid  <= 1'b0;
      r_s2_gray   <= 1'b0;
      r_s2_ps     <= '0;
      r_s2_qs     <= '0;
      r_s2_ts     <= '0;
      r_s2_v8     <= '0;
      r_s2_region <= '0;
    end else if (w_en) begin
      r_s2_valid  <= r_s1_valid;
      r_s2_gray   <= r_s1_gray;
      r_s2_ps     <= 8'd255 - r_s1_s8;
      r_s2_qs     <= 8'd255 - CW'(w_prod_q >> 8);
      r_s2_ts     <= 8'd255 - CW'(w_prod_t >> 8);
      r_s2_v8     <= r_s1_v8;
      r_s2_region <= r_s1_region;
    end
  end

  // ---------------- S3: scale by value ----------------
  logic [PW-1:0] w_prod_p3, w_prod_q3, w_prod_t3;

  assign w_prod_p3 = PW'(r_s2_v8) * PW'(r_s2_ps);
  assign w_prod_q3 = PW'(r_s2_v8) * PW'(r_s2_qs);
  assign w_prod_t3 = PW'(r_s2_v8) * PW'(r_s2_ts);

  logic          r_s3_valid, r_s3_gray;
  logic [CW-1:0] r_s3_p, r_s3_q, r_s3_t, r_s3_v8;
  logic [2:0]    r_s3_region;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_s3_valid  <= 1'b0;
      r_s3_gray   <= 1'b0;
      r_s3_p      <= '0;
      r_s3_q      <= '0;
      r_s3_t      <= '0;
      r_s3_v8     <= '0;
      r_s3_region <= '0;
    end else if (w_en) begin
      r_s3_valid  <= r_s2_valid;
      r_s3_gray   <= r_s2_gray;
      r_s3_p      <= CW'(w_prod_p3 >> 8);
      r_s3_q      <= CW'(w_prod_q3 >> 8);
      r_s3_t      <= CW'(w_prod_t3 >> 8);
      r_s3_v8     <= r_s2_v8;
      r_s3_region <= r_s2_region;
    end
  end

  // ---------------- S4: channel select by sextant ----------------
  logic [CW-1:0] w_r8, w_g8, w_b8;

  always_comb begin
    w_r8 = r_s3_v8;
    w_g8 = r_s3_t;
    w_b8 = r_s3_p;
    if (r_s3_gray) begin
      w_g8 = r_s3_v8;
      w_b8 = r_s3_v8;
    end else begin
      case (r_s3_region)
        RGN_1:   begin w_r8 = r_s3_q;  w_g8 = r_s3_v8; w_b8 = r_s3_p;  end
        RGN_2:   begin w_r8 = r_s3_p;  w_g8 = r_s3_v8; w_b8 = r_s3_t;  end
        RGN_3:   begin w_r8 = r_s3_p;  w_g8 = r_s3_q;  w_b8 = r_s3_v8; end
        RGN_4:   begin w_r8 = r_s3_t;  w_g8 = r_s3_p;  w_b8 = r_s3_v8; end
        RGN_5:   begin w_r8 = r_s3_v8; w_g8 = r_s3_p;  w_b8 = r_s3_q;  end
        default: begin w_r8 = r_s3_v8; w_g8 = r_s3_t;  w_b8 = r_s3_p;  end
      endcase
    end
  end

  logic          r_s4_valid;
  logic [CW-1:0] r_s4_r, r_s4_g, r_s4_b;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_s4_valid <= 1'b0;
      r_s4_r     <= '0;
      r_s4_g     <= '0;
      r_s4_b     <= '0;
    end else if (w_en) begin
      r_s4_valid <= r_s3_valid;
      r_s4_r     <= w_r8;
      r_s4_g     <= w_g8;
      r_s4_b     <= w_b8;
    end
  end

  // ---------------- Output: narrow to 4 bits per channel ----------------
  function automatic logic [NW-1:0] narrow(input logic [CW-1:0] c);
`ifdef HSV_ROUND_EN
    logic [CW:0] sum;
    sum    = (CW+1)'(c) + 9'd8;
    narrow = sum[CW] ? 4'hF : NW'(sum >> 4);
`else
    narrow = NW'(c >> 4);
`endif
  endfunction

  logic        r_valid_out;
  logic [11:0] r_rgb;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_valid_out <= 1'b0;
      r_rgb       <= 12'h000;
    end else if (w_en) begin
      r_valid_out <= r_s4_valid;
      r_rgb       <= {narrow(r_s4_r), narrow(r_s4_g), narrow(r_s4_b)};
    end
  end

  assign bus.valid_out = r_valid_out;
  assign bus.rgb       = r_rgb;

endmodule

// File: tb/tb_hsv_to_rgb.sv
// Scoreboard bench for hsv_to_rgb: directed vectors, stall, bubble, async reset and full sweep.
module tb_hsv_to_rgb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hsv_to_rgb_if bus ();

  hsv_to_rgb dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [11:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] nar(input int c);
`ifdef HSV_ROUND_EN
    int r;
    r = (c + 8) >> 4;
    return (r > 15) ? 4'hF : 4'(r);
`else
    return 4'(c >> 4);
`endif
  endfunction

  // Reference model written straight from the stage equations
  function automatic logic [11:0] model(input logic [11:0] x);
    int h8, s8, v8, region, rem, ps, qs, ts, p, q, t, r, g, b;
    h8 = int'(x[11:8]) * 17;
    s8 = int'(x[7:4]) * 17;
    v8 = int'(x[3:0]) * 17;
    region = h8 / 43;
    rem = (h8 - 43 * region) * 6;
    ps = 255 - s8;
    qs = 255 - ((s8 * rem) >> 8);
    ts = 255 - ((s8 * (255 - rem)) >> 8);
    p = (v8 * ps) >> 8;
    q = (v8 * qs) >> 8;
    t = (v8 * ts) >> 8;
    case (region)
      0: begin r = v8; g = t;  b = p;  end
      1: begin r = q;  g = v8; b = p;  end
      2: begin r = p;  g = v8; b = t;  end
      3: begin r = p;  g = q;  b = v8; end
      4: begin r = t;  g = p;  b = v8; end
      default: begin r = v8; g = p; b = q; end
    endcase
    if (x[7:4] == 4'd0) begin r = v8; g = v8; b = v8; end
    return {nar(r), nar(g), nar(b)};
  endfunction

  // Monitor: one pop per completed output handshake
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if ($isunknown({bus.valid_out, bus.rgb})) begin
        n_tests++;
        n_fail++;
        $display("FAIL x_on_output: got valid_out=%b rgb=%h expected known values", bus.valid_out, bus.rgb);
      end else if (bus.valid_out && bus.ready_in) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got rgb=%h expected no pixel", bus.rgb);
        end else begin
          check("rgb", 32'(bus.rgb), 32'(sb.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    repeat (n) tick();
  endtask

  // Present a pixel until accepted; optional random downstream stalls
  task automatic push_px(input logic [11:0] x, input logic [11:0] exp, input bit rnd);
    bit acc;
    bus.valid_in = 1'b1;
    bus.hsv      = x;
    acc = 1'b0;
    while (!acc) begin
      bus.ready_in = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
      @(posedge clk);
      acc = bus.ready_in;
      #1;
    end
    sb.push_back(exp);
  endtask

  logic [11:0] dir_in [4] = '{12'h5FF, 12'hAFF, 12'h508, 12'h3F0};
`ifdef HSV_ROUND_EN
  logic [11:0] dir_exp[4] = '{12'h0F0, 12'h01F, 12'h999, 12'h000};
  localparam logic [11:0] RED = 12'hF00;
`else
  logic [11:0] dir_exp[4] = '{12'h0F0, 12'h00F, 12'h888, 12'h000};
  localparam logic [11:0] RED = 12'hF00;
`endif

  initial begin
    logic [12:0] pre;
    int          pat[5] = '{1, 0, 1, 1, 0};
    logic        obs[10];
    int          budget;

    rst_n        = 1'b0;
    bus.valid_in = 1'b0;
    bus.hsv      = 12'h000;
    bus.ready_in = 1'b1;
    repeat (3) tick();
    check("reset_valid_out", 32'(bus.valid_out), 32'd0);
    check("reset_rgb", 32'(bus.rgb), 32'h000);
    check("ready_out_follows", 32'(bus.ready_out), 32'd1);
    rst_n = 1'b1;
    tick();

    // First pixel latency: visible after the 4th edge following acceptance
    push_px(12'h0FF, RED, 1'b0);
    bus.valid_in = 1'b0;
    repeat (3) tick();
    check("latency_not_early", 32'(bus.valid_out), 32'd0);
    tick();
    check("latency_valid", 32'(bus.valid_out), 32'd1);
    idle(4);

    // Back-to-back directed vectors
    for (int i = 0; i < 4; i++) push_px(dir_in[i], dir_exp[i], 1'b0);
    idle(6);

    // Stall with two pixels in flight; a third waits upstream
    push_px(12'h2F8, model(12'h2F8), 1'b0);
    push_px(12'hC7F, model(12'hC7F), 1'b0);
    idle(3);
    check("stall_pre_valid", 32'(bus.valid_out), 32'd1);
    bus.ready_in = 1'b0;
    bus.valid_in = 1'b1;
    bus.hsv      = 12'h8FF;
    #1;
    pre = {bus.valid_out, bus.rgb};
    check("stall_ready_out", 32'(bus.ready_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", 32'({bus.valid_out, bus.rgb}), 32'(pre));
      check("stall_ready_out", 32'(bus.ready_out), 32'd0);
    end
    push_px(12'h8FF, model(12'h8FF), 1'b0);
    idle(8);
    check("stall_drained", 32'(sb.size()), 32'd0);

    // Bubble pattern reproduced 4 cycles later
    bus.ready_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.valid_in = (i < 5) ? pat[i][0] : 1'b0;
      bus.hsv      = 12'(12'h1A0 + i * 12'h111);
      tick();
      if (i < 5 && pat[i] == 1) sb.push_back(model(12'(12'h1A0 + i * 12'h111)));
      obs[i] = bus.valid_out;
    end
    for (int i = 0; i < 4; i++) check("bubble_lead", 32'(obs[i]), 32'd0);
    for (int i = 0; i < 5; i++) check("bubble_pattern", 32'(obs[i+4]), 32'(pat[i]));
    idle(4);

    // Asynchronous reset with a full pipeline
    for (int i = 0; i < 5; i++) push_px(12'(12'h3C5 + i * 12'h211), model(12'(12'h3C5 + i * 12'h211)), 1'b0);
    push_px(12'h4DF, model(12'h4DF), 1'b0);
    check("prereset_valid", 32'(bus.valid_out), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(bus.valid_out), 32'd0);
    check("async_reset_rgb", 32'(bus.rgb), 32'h000);
    sb.delete();
    bus.valid_in = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    push_px(12'h0FF, RED, 1'b0);
    bus.valid_in = 1'b0;
    repeat (3) tick();
    check("post_reset_no_stale", 32'(bus.valid_out), 32'd0);
    tick();
    check("post_reset_valid", 32'(bus.valid_out), 32'd1);
    idle(3);

    // Exhaustive sweep with random downstream stalls
    for (int x = 0; x < 4096; x++) push_px(12'(x), model(12'(x)), 1'b1);
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;

    budget = 40;
    while (sb.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    check("final_drain", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
